// File: rtl/cluster_boot_sequencer.sv
// cluster_boot_sequencer: writes the entry point into each selected cluster's boot register,
// then pulses debug_req on all cores of those clusters.
module cluster_boot_sequencer #(
  parameter int unsigned NumClusters = 4,
  parameter int unsigned NumCores = 4,
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64,
  parameter logic [AddrWidth-1:0] BootRegBase = 48'h0000_5102_0058,
  parameter logic [AddrWidth-1:0] ClusterStride = 48'h0000_0004_0000,
  parameter int unsigned StartDelay = 1000,
  parameter int unsigned WakeCycles = 1,
  parameter int unsigned RspTimeout = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic [31:0]                     entry_point_i,
  input  logic [NumClusters-1:0]          cluster_mask_i,
  output logic [AddrWidth-1:0]            q_addr_o,
  output logic [DataWidth-1:0]            q_data_o,
  output logic                            q_write_o,
  output logic [DataWidth/8-1:0]          q_strb_o,
  output logic                            q_valid_o,
  input  logic                            q_ready_i,
  input  logic                            p_valid_i,
  input  logic                            p_error_i,
  output logic                            p_ready_o,
  output logic [NumClusters*NumCores-1:0] debug_req_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            error_o,
  output logic [3:0]                      err_cluster_o
);
  typedef enum logic [2:0] {IDLE, DELAY, SEL, REQ, RSP, WAKE, FIN} state_t;
  state_t state;
  logic [31:0] entry, cnt;
  logic [NumClusters-1:0] mask, cap;
  logic [3:0] idx, sel_idx;
  logic wrote;
  logic [NumClusters*NumCores-1:0] wake_vec;
  assign q_write_o = q_valid_o;
  assign q_strb_o = {(DataWidth/8){q_valid_o}};
  always_comb begin
    sel_idx = '0;
    for (int i = NumClusters - 1; i >= 0; i--) if (mask[i]) sel_idx = 4'(i);
    wake_vec = '0;
    for (int i = 0; i < NumClusters; i++) wake_vec[i*NumCores +: NumCores] = {NumCores{cap[i]}};
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      entry <= '0;
      cnt <= '0;
      mask <= '0;
      cap <= '0;
      idx <= '0;
      wrote <= 1'b0;
      q_addr_o <= '0;
      q_data_o <= '0;
      q_valid_o <= 1'b0;
      p_ready_o <= 1'b0;
      debug_req_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      error_o <= 1'b0;
      err_cluster_o <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          entry <= entry_point_i;
          mask <= cluster_mask_i;
          cap <= cluster_mask_i;
          cnt <= '0;
          wrote <= 1'b0;
          done_o <= 1'b0;
          error_o <= 1'b0;
          busy_o <= 1'b1;
          state <= DELAY;
        end
        DELAY: begin
          cnt <= cnt + 32'd1;
          if (cnt + 32'd1 >= StartDelay) state <= SEL;
        end
        SEL: if (mask != '0) begin
          idx <= sel_idx;
          q_addr_o <= BootRegBase + ClusterStride * AddrWidth'(sel_idx);
          q_data_o <= DataWidth'(entry);
          q_valid_o <= 1'b1;
          state <= REQ;
        end else if (wrote) begin
          debug_req_o <= wake_vec;
          cnt <= '0;
          state <= WAKE;
        end else begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state <= FIN;
        end
        REQ: if (q_ready_i) begin
          q_valid_o <= 1'b0;
          p_ready_o <= 1'b1;
          cnt <= '0;
          state <= RSP;
        end
        RSP: begin
          cnt <= cnt + 32'd1;
          // a response in the expiry cycle wins over the timeout
          if (p_valid_i && !p_error_i) begin
            p_ready_o <= 1'b0;
            mask <= mask & ~(NumClusters'(1) << idx);
            wrote <= 1'b1;
            state <= SEL;
          end else if (p_valid_i || (RspTimeout != 0 && cnt + 32'd1 >= RspTimeout)) begin
            p_ready_o <= 1'b0;
            error_o <= 1'b1;
            err_cluster_o <= idx;
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state <= FIN;
          end
        end
        WAKE: begin
          cnt <= cnt + 32'd1;
          if (cnt + 32'd1 >= WakeCycles) begin
            debug_req_o <= '0;
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cluster_boot_sequencer.sv
// tb_cluster_boot_sequencer: directed and random boot sequences checked against a
// per-sequence expectation derived from mask, responder latencies and error injection.
module tb_cluster_boot_sequencer;
  logic clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0;
  logic [31:0] entry_point_i = '0;
  logic [3:0] cluster_mask_i = '0;
  logic q_ready_i = 1'b0, p_valid_i = 1'b0, p_error_i = 1'b0;
  logic [47:0] q_addr_o;
  logic [63:0] q_data_o;
  logic q_write_o, q_valid_o, p_ready_o, busy_o, done_o, error_o;
  logic [7:0] q_strb_o;
  logic [15:0] debug_req_o;
  logic [3:0] err_cluster_o;
  int n_cmp = 0, n_bad = 0;
  int rdy_lat[4], rsp_lat[4];
  bit perr[4];
  cluster_boot_sequencer #(.WakeCycles(3), .RspTimeout(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .entry_point_i(entry_point_i),
    .cluster_mask_i(cluster_mask_i), .q_addr_o(q_addr_o), .q_data_o(q_data_o),
    .q_write_o(q_write_o), .q_strb_o(q_strb_o), .q_valid_o(q_valid_o), .q_ready_i(q_ready_i),
    .p_valid_i(p_valid_i), .p_error_i(p_error_i), .p_ready_o(p_ready_o),
    .debug_req_o(debug_req_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .err_cluster_o(err_cluster_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic set_resp(input int r, input int p);
    for (int c = 0; c < 4; c++) begin
      rdy_lat[c] = r;
      rsp_lat[c] = p;
      perr[c] = 1'b0;
    end
  endtask
  task automatic run(input logic [3:0] mask, input logic [31:0] entry, input bit restart_mid);
    int exp_cl[$];
    bit exp_err = 0;
    int exp_ec = 0;
    logic [15:0] exp_pulse = '0;
    int cyc = 0, first_q = -1, nreq = 0, qv = 0, pr = 0, pulse_cyc = 0, cur;
    bit got_done = 0;
    for (int c = 0; c < 4; c++)
      if (mask[c] && !exp_err) begin
        exp_cl.push_back(c);
        if (perr[c] || rsp_lat[c] > 8) begin
          exp_err = 1;
          exp_ec = c;
        end
      end
    if (!exp_err) for (int c = 0; c < 4; c++) if (mask[c]) exp_pulse[c*4 +: 4] = 4'hF;
    @(negedge clk_i);
    start_i = 1'b1;
    entry_point_i = entry;
    cluster_mask_i = mask;
    @(negedge clk_i);
    start_i = 1'b0;
    entry_point_i = ~entry;
    cluster_mask_i = ~mask;
    chk("busy_after_start", busy_o, 1);
    chk("done_cleared", done_o, 0);
    while (!got_done && cyc < 4000) begin
      cyc++;
      start_i = restart_mid && cyc == 10;
      if (start_i) cluster_mask_i = 4'hF;
      if (done_o) got_done = 1;
      cur = (nreq > 0 && nreq <= exp_cl.size()) ? exp_cl[nreq-1] : 0;
      if (q_valid_o) begin
        if (first_q < 0) first_q = cyc;
        if (nreq < exp_cl.size()) begin
          chk("q_addr", q_addr_o, 48'h5102_0058 + 48'(exp_cl[nreq]) * 48'h4_0000);
          chk("q_data", q_data_o, {32'h0, entry});
          chk("q_write", q_write_o, 1);
          chk("q_strb", q_strb_o, 8'hFF);
          qv++;
          q_ready_i = qv > rdy_lat[exp_cl[nreq]];
          if (q_ready_i) begin
            nreq++;
            qv = 0;
          end
        end else begin
          chk("unexpected_req", q_valid_o, 0);
          q_ready_i = 1'b1;
        end
      end else q_ready_i = 1'($urandom_range(0, 1));
      if (p_ready_o) begin
        pr++;
        p_valid_i = pr == rsp_lat[cur];
        p_error_i = p_valid_i ? perr[cur] : 1'($urandom_range(0, 1));
        if (p_valid_i) pr = 0;
      end else begin
        pr = 0;
        p_valid_i = 1'($urandom_range(0, 1));
        p_error_i = 1'($urandom_range(0, 1));
      end
      chk("one_outstanding", q_valid_o & p_ready_o, 0);
      if (debug_req_o != '0) begin
        pulse_cyc++;
        chk("pulse_value", debug_req_o, exp_pulse);
      end
      @(negedge clk_i);
    end
    start_i = 1'b0;
    q_ready_i = 1'b0;
    p_valid_i = 1'b0;
    p_error_i = 1'b0;
    chk("done_seen", got_done, 1);
    chk("requests", nreq, exp_cl.size());
    chk("pulse_cycles", pulse_cyc, exp_pulse != '0 ? 3 : 0);
    chk("error", error_o, exp_err);
    if (exp_err) chk("err_cluster", err_cluster_o, exp_ec);
    if (mask != '0) chk("start_delay", first_q >= 1001 && first_q <= 1004, 1);
    chk("done_sticky", done_o, 1);
    chk("busy_idle", busy_o, 0);
  endtask
  initial begin
    bit found;
    repeat (3) @(negedge clk_i);
    chk("rst_q_valid", q_valid_o, 0);
    chk("rst_p_ready", p_ready_o, 0);
    chk("rst_debug", debug_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_err_cluster", err_cluster_o, 0);
    chk("rst_q_addr", q_addr_o, 0);
    chk("rst_q_data", q_data_o, 0);
    rst_ni = 1'b1;
    set_resp(0, 1);
    run(4'b1111, 32'h8000_0000, 0);
    rdy_lat[2] = 5;
    run(4'b0100, 32'h1234_5678, 0);
    set_resp(0, 1);
    perr[1] = 1'b1;
    run(4'b0011, 32'hDEAD_BEEF, 0);
    set_resp(0, 20);
    run(4'b0110, 32'h0000_1000, 0);
    set_resp(0, 8);
    run(4'b0110, 32'h0000_2000, 0);
    set_resp(1, 2);
    run(4'b0000, 32'h0000_3000, 0);
    run(4'b1010, 32'hCAFE_0000, 1);
    set_resp(50, 1);
    start_i = 1'b1;
    cluster_mask_i = 4'hF;
    @(negedge clk_i);
    start_i = 1'b0;
    found = 0;
    for (int i = 0; i < 1200 && !found; i++) begin
      if (q_valid_o) found = 1;
      else @(negedge clk_i);
    end
    chk("wait_req", found, 1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_req_q_valid", q_valid_o, 0);
    chk("rst_mid_req_busy", busy_o, 0);
    rst_ni = 1'b1;
    found = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (q_valid_o || debug_req_o != '0) found = 1;
    end
    chk("quiet_after_rst", found, 0);
    set_resp(0, 1);
    run(4'b1111, 32'h8000_0000, 0);
    start_i = 1'b1;
    cluster_mask_i = 4'b0101;
    @(negedge clk_i);
    start_i = 1'b0;
    found = 0;
    for (int i = 0; i < 1200 && !found; i++) begin
      q_ready_i = q_valid_o;
      p_valid_i = p_ready_o;
      if (debug_req_o != '0) found = 1;
      else @(negedge clk_i);
    end
    q_ready_i = 1'b0;
    p_valid_i = 1'b0;
    chk("wait_wake", found, 1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_wake_debug", debug_req_o, 0);
    chk("rst_mid_wake_done", done_o, 0);
    rst_ni = 1'b1;
    found = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (debug_req_o != '0) found = 1;
    end
    chk("no_pulse_after_rst", found, 0);
    repeat (6) begin
      for (int c = 0; c < 4; c++) begin
        rdy_lat[c] = $urandom_range(0, 3);
        rsp_lat[c] = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(1, 8);
        perr[c] = $urandom_range(0, 7) == 0;
      end
      run(4'($urandom_range(0, 15)), $urandom, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cluster_boot_sequencer.md
CLUSTER_BOOT_SEQUENCER -- requirements
Module: cluster_boot_sequencer

Interface
REQ-001 SHALL have parameter NumClusters, default 4: number of clusters to boot (1..16).
REQ-002 SHALL have parameter NumCores, default 4: cores per cluster.
REQ-003 SHALL have parameter AddrWidth, default 48: request address width.
REQ-004 SHALL have parameter DataWidth, default 64: request data width.
REQ-005 SHALL have parameter BootRegBase, default 48'h0000_5102_0058: boot-control register address of cluster 0.
REQ-006 SHALL have parameter ClusterStride, default 48'h0000_0004_0000: address distance between consecutive clusters.
REQ-007 SHALL have parameter StartDelay, default 1000: idle cycles between start and the first request.
REQ-008 SHALL have parameter WakeCycles, default 1: debug_req pulse width in cycles (>=1).
REQ-009 SHALL have parameter RspTimeout, default 255: max cycles waiting for a response (0 = no timeout).
REQ-010 SHALL use one clock, clk_i; reset rst_ni is synchronous, active-low.
REQ-011 Ports, in order (name direction width meaning):
 clk_i in 1 clock
 rst_ni in 1 synchronous active-low reset
 start_i in 1 begin boot sequence (sampled in IDLE only)
 entry_point_i in 32 boot address, captured at start
 cluster_mask_i in NumClusters clusters to boot, captured at start
 q_addr_o out AddrWidth request address
 q_data_o out DataWidth request write data
 q_write_o out 1 write flag (always 1 when q_valid_o)
 q_strb_o out DataWidth/8 byte strobe (all ones when q_valid_o)
 q_valid_o out 1 request valid
 q_ready_i in 1 request accepted
 p_valid_i in 1 response valid
 p_error_i in 1 response error, qualified by p_valid_i
 p_ready_o out 1 response ready
 debug_req_o out NumClusters*NumCores wake pulse, bits [c*NumCores +: NumCores] belong to cluster c
 busy_o out 1 sequence in progress
 done_o out 1 sequence finished, sticky until next start
 error_o out 1 sequence aborted, sticky until next start
 err_cluster_o out 4 index of cluster that failed

Function
REQ-012 SHALL implement FSM states IDLE, DELAY, SEL, REQ, RSP, WAKE, FIN.
REQ-013 IDLE: start_i=1 -> capture entry_point_i and cluster_mask_i, clear done_o/error_o, go to DELAY; busy_o=1 in every state except IDLE and FIN.
REQ-014 DELAY: count StartDelay cycles, then SEL; StartDelay=0 -> SEL the next cycle.
REQ-015 SEL: pick lowest-index set bit of the remaining mask -> REQ; remaining mask empty -> WAKE if at least one cluster was written, else FIN with done_o=1 and no pulse.
REQ-016 REQ: q_valid_o=1, q_addr_o=BootRegBase+idx*ClusterStride (truncated to AddrWidth), q_data_o={zero-extend, entry_point}; all q_* SHALL stay stable until the q_valid_o&&q_ready_i cycle, then RSP.
REQ-017 RSP: p_ready_o=1; on p_valid_i: p_error_i=0 -> clear the mask bit, go to SEL; p_error_i=1 -> error_o=1, err_cluster_o=idx, go to FIN.
REQ-018 RSP timeout: RspTimeout!=0 and RspTimeout cycles without p_valid_i -> error_o=1, err_cluster_o=idx, go to FIN.
REQ-019 A response arriving in the same cycle as the timeout expires SHALL take precedence over the timeout.
REQ-020 On any error, no debug_req_o SHALL be issued.
REQ-021 WAKE: assert debug_req_o for exactly WakeCycles cycles on all cores of every captured-mask cluster and on no others, then FIN.
REQ-022 FIN: done_o=1 (also set on error), busy_o=0; return to IDLE the next cycle; done_o and error_o stay set.
REQ-023 start_i outside IDLE SHALL be ignored.
REQ-024 p_ready_o=0 outside RSP.
REQ-025 q_valid_o=0 outside REQ.
REQ-026 At most one request SHALL be outstanding.

Reset
REQ-027 rst_ni=0 at a clock edge -> state IDLE and all counters cleared.
REQ-028 Reset values: q_valid_o=0, p_ready_o=0, debug_req_o=0, busy_o=0, done_o=0, error_o=0, err_cluster_o=0, q_addr_o=0, q_data_o=0.
REQ-029 Reset mid-sequence (including during WAKE) SHALL abort immediately with no further request or pulse.

Verification
REQ-030 Defaults, mask=4'b1111, entry=0x8000_0000, q_ready/p_valid answered in 1 cycle -> first q_valid_o 1000+ cycles after start; four writes to 0x5102_0058, 0x5106_0058, 0x510A_0058, 0x510E_0058, each with data 0x0000_0000_8000_0000; then debug_req_o=16'hFFFF for 1 cycle; then done_o=1.
REQ-031 mask=4'b0100, WakeCycles=3, q_ready_i held low 5 cycles -> q_addr_o stable at 0x510A_0058 for 6 cycles; debug_req_o=16'h0F00 for 3 cycles.
REQ-032 mask=4'b0011, p_error_i=1 on the cluster 1 response -> error_o=1, err_cluster_o=1, debug_req_o never nonzero, done_o=1.
REQ-033 RspTimeout=8, no p_valid_i -> error after 8 RSP cycles, err_cluster_o=lowest masked index; p_valid_i on cycle 8 -> no error.
REQ-034 mask=0 -> done_o=1, no request, no pulse.
REQ-035 rst_ni low mid-REQ -> q_valid_o=0 next cycle; later start_i re-runs cleanly.
REQ-036 start_i pulsed while busy -> ignored.
